// File: rtl/hwpe_stream_rr_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// hwpe_stream_sched_package
//   Shared types and constants for the round-robin stream scheduler.
//   - sched_state_t  : arbitration FSM state (IDLE, LOCKED)
//   - MAX_BURST_DEFAULT : default maximum beats per grant
//   - sched_status_t : packed status bundle {busy, gnt}; gnt is sized for the
//                      largest supported requester count (NB_IN_MAX).
// -----------------------------------------------------------------------------
package hwpe_stream_sched_package;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } sched_state_t;

    localparam int MAX_BURST_DEFAULT = 16;
    localparam int NB_IN_MAX         = 32;

    typedef struct packed {
        logic                 busy;
        logic [NB_IN_MAX-1:0] gnt;
    } sched_status_t;

endpackage

// File: rtl/hwpe_stream_rr_scheduler_pick.sv
// -----------------------------------------------------------------------------
// hwpe_stream_rr_pick
//   Combinational rotate-priority encoder: returns the first index k in the
//   order ptr, ptr+1, ... (mod NB_IN) whose valid bit is set.
//   Ports:
//     valid [NB_IN]  request vector
//     ptr   [IDX_W]  highest-priority index (must be < NB_IN)
//     any            at least one request present
//     idx   [IDX_W]  selected index (0 when any=0)
// -----------------------------------------------------------------------------
module hwpe_stream_rr_pick #(
    parameter  int NB_IN = 4,
    localparam int IDX_W = $clog2(NB_IN)
) (
    input  logic [NB_IN-1:0] valid,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        logic [IDX_W-1:0] k;
        // NOTE: every output of a combinational block gets a default before any
        // conditional assignment, otherwise synthesis infers a latch.
        any = 1'b0;
        idx = '0;
        k   = ptr;
        for (int i = 0; i < NB_IN; i++) begin
            if (!any && valid[k]) begin
                any = 1'b1;
                idx = k;
            end
            // Explicit wrap keeps this correct for non-power-of-two NB_IN.
            k = (k == IDX_W'(NB_IN - 1)) ? '0 : k + IDX_W'(1);
        end
    end

endmodule

// File: rtl/hwpe_stream_rr_scheduler.sv
// -----------------------------------------------------------------------------
// hwpe_stream_rr_scheduler
//   Shares one stream sink among NB_IN stream sources with round-robin,
//   burst-granular arbitration. A winner keeps the output for up to L beats,
//   where L is burst_len_i (0 -> 1, > MAX_BURST -> MAX_BURST) sampled when the
//   grant is locked. Routing is combinational; a grant issued while the sink
//   stalls is frozen so data/valid never change under backpressure.
//   Ports:
//     clk_i, rst_i        clock, synchronous active-high reset
//     enable_i            gates new grants only
//     burst_len_i         beats per grant
//     release_idle_i      drop a locked grant when its source goes not-valid
//     in_data/strb/valid  flattened requester streams (index k at slice k)
//     in_ready            per-requester ready
//     out_data/strb/valid/ready  shared output stream
//     busy_o              grant locked
//     gnt_o               one-hot current grant
//   Optional (HWPE_STREAM_RR_SCHED_STATS_EN):
//     clear_stats_i       clears per-input beat counters
//     beat_cnt_o          NB_IN x 32-bit saturating handshake counters
// -----------------------------------------------------------------------------
module hwpe_stream_rr_scheduler
    import hwpe_stream_sched_package::*;
#(
    parameter  int NB_IN      = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int MAX_BURST  = MAX_BURST_DEFAULT,
    localparam int BURST_W    = $clog2(MAX_BURST + 1),
    localparam int IDX_W      = $clog2(NB_IN),
    localparam int STRB_W     = DATA_WIDTH / 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        enable_i,
    input  logic [BURST_W-1:0]          burst_len_i,
    input  logic                        release_idle_i,
    input  logic [NB_IN*DATA_WIDTH-1:0] in_data,
    input  logic [NB_IN*STRB_W-1:0]     in_strb,
    input  logic [NB_IN-1:0]            in_valid,
    output logic [NB_IN-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic [STRB_W-1:0]           out_strb,
    output logic                        out_valid,
    input  logic                        out_ready,
`ifdef HWPE_STREAM_RR_SCHED_STATS_EN
    input  logic                        clear_stats_i,
    output logic [NB_IN*32-1:0]         beat_cnt_o,
`endif
    output logic                        busy_o,
    output logic [NB_IN-1:0]            gnt_o
);

    sched_state_t       state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   gnt_q, gnt_d;
    logic [BURST_W-1:0] cnt_q, cnt_d;
    logic [BURST_W-1:0] len_q, len_d;
    logic [BURST_W-1:0] eff_len;

    logic               pick_any;
    logic [IDX_W-1:0]   pick_idx;
    logic               grant_vld;
    logic [IDX_W-1:0]   grant_idx;
    logic [NB_IN-1:0]   gnt_vec;
    sched_status_t      status;

    logic [DATA_WIDTH-1:0] in_data_arr [NB_IN];
    logic [STRB_W-1:0]     in_strb_arr [NB_IN];

    for (genvar k = 0; k < NB_IN; k++) begin : g_unpack
        assign in_data_arr[k] = in_data[k*DATA_WIDTH +: DATA_WIDTH];
        assign in_strb_arr[k] = in_strb[k*STRB_W +: STRB_W];
    end

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NB_IN - 1)) ? '0 : i + IDX_W'(1);
    endfunction

    always_comb begin
        eff_len = burst_len_i;
        if (burst_len_i == '0)
            eff_len = BURST_W'(1);
        else if (burst_len_i > BURST_W'(MAX_BURST))
            eff_len = BURST_W'(MAX_BURST);
    end

    hwpe_stream_rr_pick #(
        .NB_IN (NB_IN)
    ) i_pick (
        .valid (in_valid),
        .ptr   (ptr_q),
        .any   (pick_any),
        .idx   (pick_idx)
    );

    // Next-state and grant selection. While rst_i is high no grant is issued,
    // so a reset landing mid-burst completes no beat in that cycle.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        grant_vld = 1'b0;
        grant_idx = gnt_q;

        if (!rst_i) begin
            case (state_q)
                IDLE: begin
                    if (enable_i && pick_any) begin
                        grant_vld = 1'b1;
                        grant_idx = pick_idx;
                        len_d     = eff_len;
                        if (out_ready && eff_len == BURST_W'(1)) begin
                            ptr_d = next_idx(pick_idx);
                        end else begin
                            // Stalled: lock with zero beats so the grant
                            // cannot move while data is presented.
                            gnt_d   = pick_idx;
                            cnt_d   = out_ready ? BURST_W'(1) : '0;
                            state_d = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    grant_vld = 1'b1;
                    grant_idx = gnt_q;
                    if (in_valid[gnt_q]) begin
                        if (out_ready) begin
                            if (cnt_q + BURST_W'(1) == len_q) begin
                                ptr_d   = next_idx(gnt_q);
                                state_d = IDLE;
                            end else begin
                                cnt_d = cnt_q + BURST_W'(1);
                            end
                        end
                    end else if (release_idle_i) begin
                        ptr_d   = next_idx(gnt_q);
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        gnt_vec = '0;
        if (grant_vld)
            gnt_vec[grant_idx] = 1'b1;
    end

    assign out_valid = grant_vld & in_valid[grant_idx];
    assign out_data  = grant_vld ? in_data_arr[grant_idx] : '0;
    assign out_strb  = grant_vld ? in_strb_arr[grant_idx] : '0;
    assign in_ready  = gnt_vec & {NB_IN{out_ready}};

    assign status.busy = !rst_i && (state_q == LOCKED);
    assign status.gnt  = NB_IN_MAX'(gnt_vec);
    assign busy_o      = status.busy;
    assign gnt_o       = NB_IN'(status.gnt);

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

`ifdef HWPE_STREAM_RR_SCHED_STATS_EN
    logic [31:0] beat_cnt_q [NB_IN];

    // Clear takes priority over a same-cycle increment.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_stats_i) begin
            for (int k = 0; k < NB_IN; k++)
                beat_cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < NB_IN; k++)
                if (in_valid[k] && in_ready[k] && beat_cnt_q[k] != '1)
                    beat_cnt_q[k] <= beat_cnt_q[k] + 32'd1;
        end
    end

    for (genvar k = 0; k < NB_IN; k++) begin : g_stats_out
        assign beat_cnt_o[k*32 +: 32] = beat_cnt_q[k];
    end
`endif

endmodule

// File: tb/tb_hwpe_stream_rr_scheduler.sv
module tb_hwpe_stream_rr_scheduler;

    localparam int NB_IN  = 4;
    localparam int DW     = 32;
    localparam int SW     = DW / 8;
    localparam int BW     = 5;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              enable_i;
    logic [BW-1:0]     burst_len_i;
    logic              release_idle_i;
    logic [NB_IN*DW-1:0] in_data;
    logic [NB_IN*SW-1:0] in_strb;
    logic [NB_IN-1:0]  in_valid;
    logic [NB_IN-1:0]  in_ready;
    logic [DW-1:0]     out_data;
    logic [SW-1:0]     out_strb;
    logic              out_valid;
    logic              out_ready;
    logic              busy_o;
    logic [NB_IN-1:0]  gnt_o;
`ifdef HWPE_STREAM_RR_SCHED_STATS_EN
    logic              clear_stats_i;
    logic [NB_IN*32-1:0] beat_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    hwpe_stream_rr_scheduler #(
        .NB_IN      (NB_IN),
        .DATA_WIDTH (DW),
        .MAX_BURST  (16)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .enable_i       (enable_i),
        .burst_len_i    (burst_len_i),
        .release_idle_i (release_idle_i),
        .in_data        (in_data),
        .in_strb        (in_strb),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_data       (out_data),
        .out_strb       (out_strb),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
`ifdef HWPE_STREAM_RR_SCHED_STATS_EN
        .clear_stats_i  (clear_stats_i),
        .beat_cnt_o     (beat_cnt_o),
`endif
        .busy_o         (busy_o),
        .gnt_o          (gnt_o)
    );

    typedef struct {
        logic          rst;
        logic          en;
        logic [BW-1:0] len;
        logic          rel;
        logic [3:0]    vld;
        logic          rdy;
        logic [3:0]    gnt;
        logic          busy;
    } vec_t;

    vec_t vecs[$];
    vec_t v;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   row      = 0;

    function automatic logic [DW-1:0] data_of(input int k);
        return 32'hC0DE_0000 + 32'(k) * 32'h0000_1111;
    endfunction

    function automatic logic [SW-1:0] strb_of(input int k);
        return SW'(1 << k);
    endfunction

    function automatic void add(input logic rst, input logic en, input logic [BW-1:0] len,
                                input logic rel, input logic [3:0] vld, input logic rdy,
                                input logic [3:0] gnt, input logic busy);
        vec_t r;
        r.rst = rst; r.en = en; r.len = len; r.rel = rel;
        r.vld = vld; r.rdy = rdy; r.gnt = gnt; r.busy = busy;
        vecs.push_back(r);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (row %0d): got 0x%0h, expected 0x%0h", name, row, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] exp_d;
        logic [SW-1:0] exp_s;
        int            beats;
        bit            started;

        for (int k = 0; k < NB_IN; k++) begin
            in_data[k*DW +: DW] = data_of(k);
            in_strb[k*SW +: SW] = strb_of(k);
        end
        rst_i = 1'b1; enable_i = 1'b0; burst_len_i = '0; release_idle_i = 1'b0;
        in_valid = '0; out_ready = 1'b0;
`ifdef HWPE_STREAM_RR_SCHED_STATS_EN
        clear_stats_i = 1'b0;
`endif

        // 1: L=1, all valid -> 0,1,2,3,0,1
        add(1,1,1,0,4'hF,1,4'b0000,0);
        add(0,1,1,0,4'hF,1,4'b0001,0);
        add(0,1,1,0,4'hF,1,4'b0010,0);
        add(0,1,1,0,4'hF,1,4'b0100,0);
        add(0,1,1,0,4'hF,1,4'b1000,0);
        add(0,1,1,0,4'hF,1,4'b0001,0);
        add(0,1,1,0,4'hF,1,4'b0010,0);
        // 2: L=4, in0/in2 valid -> 4 beats each
        add(1,1,4,0,4'h5,1,4'b0000,0);
        add(0,1,4,0,4'h5,1,4'b0001,0);
        for (int i = 0; i < 3; i++) add(0,1,4,0,4'h5,1,4'b0001,1);
        add(0,1,4,0,4'h5,1,4'b0100,0);
        for (int i = 0; i < 3; i++) add(0,1,4,0,4'h5,1,4'b0100,1);
        add(0,1,4,0,4'h5,1,4'b0001,0);
        // 3: stall freezes grant on in1 while in0 appears
        add(1,1,1,0,4'h0,1,4'b0000,0);
        add(0,1,1,0,4'h2,0,4'b0010,0);
        add(0,1,1,0,4'h3,0,4'b0010,1);
        add(0,1,1,0,4'h3,0,4'b0010,1);
        add(0,1,1,0,4'h3,1,4'b0010,1);
        add(0,1,1,0,4'h1,1,4'b0001,0);
        // 4a: L=8, in3 drops after 2 beats, release -> IDLE, ptr wraps to 0
        add(1,1,8,1,4'h0,1,4'b0000,0);
        add(0,1,8,1,4'h8,1,4'b1000,0);
        add(0,1,8,1,4'h8,1,4'b1000,1);
        add(0,1,8,1,4'h0,1,4'b1000,1);
        add(0,1,8,1,4'h3,1,4'b0001,0);
        // 4b: no release -> grant held, burst resumes; mid-burst L change ignored
        add(1,1,8,0,4'h0,1,4'b0000,0);
        add(0,1,8,0,4'h8,1,4'b1000,0);
        add(0,1,8,0,4'h8,1,4'b1000,1);
        add(0,1,8,0,4'h1,1,4'b1000,1);
        add(0,1,8,0,4'h1,1,4'b1000,1);
        for (int i = 0; i < 6; i++) add(0,1,2,0,4'h9,1,4'b1000,1);
        add(0,1,2,0,4'h9,1,4'b0001,0);
        // 5: reset at cnt=5 of an in2 burst with ptr=2 -> re-arbitrate from 0
        add(1,1,1,0,4'h0,1,4'b0000,0);
        add(0,1,1,0,4'h2,1,4'b0010,0);
        add(0,1,8,0,4'h4,1,4'b0100,0);
        for (int i = 0; i < 4; i++) add(0,1,8,0,4'h4,1,4'b0100,1);
        add(1,1,8,0,4'h4,1,4'b0000,0);
        add(0,1,1,0,4'hA,1,4'b0010,0);
        // enable gates only new grants
        add(1,0,2,0,4'h0,1,4'b0000,0);
        add(0,0,2,0,4'hF,1,4'b0000,0);
        add(0,1,2,0,4'h1,1,4'b0001,0);
        add(0,0,2,0,4'hF,1,4'b0001,1);
        add(0,0,2,0,4'hF,1,4'b0000,0);
        // L=0 behaves as L=1
        add(1,1,0,0,4'h0,1,4'b0000,0);
        add(0,1,0,0,4'hF,1,4'b0001,0);
        add(0,1,0,0,4'hF,1,4'b0010,0);

        for (int i = 0; i < vecs.size(); i++) begin
            row = i;
            v = vecs[i];
            rst_i = v.rst; enable_i = v.en; burst_len_i = v.len;
            release_idle_i = v.rel; in_valid = v.vld; out_ready = v.rdy;
            #3;
            exp_d = '0;
            exp_s = '0;
            for (int k = 0; k < NB_IN; k++)
                if (v.gnt[k]) begin
                    exp_d = data_of(k);
                    exp_s = strb_of(k);
                end
            check("gnt_o",     64'(gnt_o),     64'(v.gnt));
            check("busy_o",    64'(busy_o),    64'(v.busy));
            check("out_valid", 64'(out_valid), 64'(|(v.gnt & v.vld)));
            check("out_data",  {28'd0, out_strb, out_data}, {28'd0, exp_s, exp_d});
            check("in_ready",  64'(in_ready),  64'(v.gnt & {4{v.rdy}}));
            @(posedge clk_i); #1;
        end

        // Burst length above MAX_BURST clamps to 16 beats.
        row = -1;
        do_reset();
        enable_i = 1'b1; burst_len_i = 5'd31; release_idle_i = 1'b0;
        in_valid = 4'b0001; out_ready = 1'b1;
        beats = 0;
        started = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #3;
            if (out_valid && out_ready && in_ready[0]) beats++;
            @(posedge clk_i); #1;
            if (busy_o) started = 1'b1;
            else if (started) break;
        end
        check("clamped_burst_beats", 64'(beats), 64'd16);

`ifdef HWPE_STREAM_RR_SCHED_STATS_EN
        begin
            int          hs;
            logic [63:0] sum;
            row = -2;
            do_reset();
            sum = '0;
            for (int k = 0; k < NB_IN; k++) sum += 64'(beat_cnt_o[k*32 +: 32]);
            check("stats_after_reset", sum, 64'd0);
            in_valid = 4'hF; enable_i = 1'b1;
            hs = 0;
            for (int c = 0; c < 5000 && hs < 1000; c++) begin
                burst_len_i = BW'($urandom_range(0, 5));
                out_ready = ($urandom_range(0, 99) >= 30);
                #3;
                if (out_valid && out_ready) hs++;
                @(posedge clk_i); #1;
            end
            check("stats_handshakes", 64'(hs), 64'd1000);
            out_ready = 1'b0;
            #3;
            sum = '0;
            for (int k = 0; k < NB_IN; k++) sum += 64'(beat_cnt_o[k*32 +: 32]);
            check("stats_sum", sum, 64'(hs));
            out_ready = 1'b1;
            clear_stats_i = 1'b1;
            @(posedge clk_i); #1;
            clear_stats_i = 1'b0;
            out_ready = 1'b0;
            #3;
            sum = '0;
            for (int k = 0; k < NB_IN; k++) sum += 64'(beat_cnt_o[k*32 +: 32]);
            check("stats_cleared", sum, 64'd0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
